iob_wishbone2iob_pipe: RTL and testbench

//  Pipelined Wishbone B4 slave to IOb master bridge. Queues up to REQ_DEPTH accepted

---
 rtl/iob_wishbone2iob_pipe.sv | 138 +++++++++++++
 tb/tb_iob_wishbone2iob_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_wishbone2iob_pipe.sv
// Pipelined Wishbone B4 slave to IOb master bridge. It queues accepted requests in a
// FIFO and issues them in order, one IOb transaction in flight, with a per-request timeout.
module iob_wishbone2iob_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [ADDR_W-1:0]           wb_adr_i,
  input  logic [DATA_W/8-1:0]         wb_sel_i,
  input  logic                        wb_we_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic [DATA_W-1:0]           wb_dat_i,
  output logic                        wb_stall_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [DATA_W-1:0]           wb_dat_o,
  output logic                        valid_o,
  output logic [ADDR_W-1:0]           address_o,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W/8-1:0]         wstrb_o,
  input  logic [DATA_W-1:0]           rdata_i,
  input  logic                        ready_i,
  output logic [$clog2(REQ_DEPTH):0]  level_o
);

  localparam int SEL_W   = DATA_W / 8;
  localparam int PTR_W   = $clog2(REQ_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int ENT_W   = ADDR_W + SEL_W + DATA_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Observable FSM state; valid_o is always equal to (state == ST_REQ).
  state_e state;

  logic [ENT_W-1:0] mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             suppress;
  logic [ENT_W-1:0] head;

  logic push, pop, flush, fifo_empty, in_req, timeout_hit, done, drop_rsp;

  // Handshakes: a Wishbone request is taken on any edge with cyc & stb & ~stall; an IOb
  // request is presented while valid_o is high and retires on the edge where ready_i is
  // high (or the wait counter expires); valid_o and the payload never change before that.
  assign flush       = ~wb_cyc_i;
  assign push        = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign fifo_empty  = (level_o == '0);
  assign in_req      = (state == ST_REQ);
  assign timeout_hit = (TIMEOUT > 0) && in_req && !ready_i && (wait_cnt == CNT_W'(TO_LAST));
  assign done        = in_req & (ready_i | timeout_hit);
  assign pop         = wb_cyc_i & ~fifo_empty & (~in_req | done);
  assign drop_rsp    = suppress | ~wb_cyc_i;
  assign head        = mem[rd_ptr];

  always_comb begin
    level_nxt = level_o;
    if (flush) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level_o + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level_o - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {wb_adr_i, (wb_we_i ? wb_sel_i : {SEL_W{1'b0}}), wb_dat_i};
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      wb_stall_o <= 1'b0;
    end else begin
      level_o    <= level_nxt;
      wb_stall_o <= (level_nxt == LVL_W'(REQ_DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= ST_IDLE;
      valid_o   <= 1'b0;
      address_o <= '0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      wait_cnt  <= '0;
      suppress  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      wb_ack_o <= done & ready_i & ~drop_rsp;
      wb_err_o <= done & ~ready_i & ~drop_rsp;
      wb_dat_o <= (done & ready_i & ~drop_rsp & (wstrb_o == '0)) ? rdata_i : '0;
      if (pop) begin
        state                           <= ST_REQ;
        valid_o                         <= 1'b1;
        {address_o, wstrb_o, wdata_o}   <= head;
        wait_cnt                        <= '0;
        suppress                        <= 1'b0;
      end else if (done) begin
        state    <= ST_IDLE;
        valid_o  <= 1'b0;
        suppress <= 1'b0;
      end else if (in_req) begin
        wait_cnt <= wait_cnt + 1'b1;
        // An abort while in flight lets IOb finish but hides the response from Wishbone.
        if (flush) suppress <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iob_wishbone2iob_pipe.sv
// Bench for iob_wishbone2iob_pipe: vector table, directed burst/abort/reset sequences and
// random traffic checked against a queue-based model of accepted requests and responses.
module tb_iob_wishbone2iob_pipe;

  localparam int TO = 8;

  logic        clk;
  logic        arst_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;
  logic        valid_o;
  logic [31:0] address_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic [31:0] rdata_i;
  logic        ready_i;
  logic [2:0]  level_o;

  iob_wishbone2iob_pipe #(
    .ADDR_W(32), .DATA_W(32), .REQ_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .arst_i(arst_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_i(wb_dat_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o), .valid_o(valid_o), .address_o(address_o),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .rdata_i(rdata_i),
    .ready_i(ready_i), .level_o(level_o)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  strb;
    logic [31:0] dat;
  } iob_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          lat;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [3:0]  exp_strb;
    int          exp_vcyc;
  } vec_t;

  iob_t exp_iob_q[$];
  rsp_t exp_rsp_q[$];

  int errors = 0;
  int checks = 0;

  // Responder controls: mode 0 fixed latency, 1 random latency, 2 hold ready low.
  int          rsp_mode  = 0;
  int          fix_lat   = 0;
  logic [31:0] fix_rdata = 32'h0;
  bit          idle_noise = 0;
  bit          suppress_cur = 0;

  int   cnt = 0;
  int   cur_lat = 0;
  bit   in_req_m = 0;
  bit   cur_ok = 0;
  iob_t cur;
  int   n_done = 0;
  int   n_rsp = 0;
  int   last_vcyc = 0;
  logic [31:0] last_adr, last_wdata, last_dat;
  logic [3:0]  last_strb;
  logic        last_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // IOb slave model: checks issue order/payload and predicts each Wishbone response
  // from the latency it chooses (ready within TO valid cycles -> ack, else err).
  always @(negedge clk) begin
    if (arst_i || !valid_o) begin
      in_req_m     = 0;
      cnt          = 0;
      suppress_cur = 0;
      ready_i      = idle_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      rdata_i      = $urandom;
    end else begin
      bit go;
      if (!in_req_m) begin
        in_req_m = 1;
        cnt      = 0;
        if (exp_iob_q.size() == 0) begin
          cur_ok = 0;
          fail_now("iob_unexpected_issue");
        end else begin
          cur    = exp_iob_q.pop_front();
          cur_ok = 1;
          chk("iob_payload", {address_o, wstrb_o, wdata_o}, cur);
        end
        cur_lat    = (rsp_mode == 1) ? $urandom_range(0, 10) : fix_lat;
        last_adr   = address_o;
        last_strb  = wstrb_o;
        last_wdata = wdata_o;
      end else if (cur_ok) begin
        chk("iob_hold", {address_o, wstrb_o, wdata_o}, cur);
      end
      go      = (rsp_mode != 2) && (cnt >= cur_lat);
      ready_i = go;
      rdata_i = (rsp_mode == 1) ? $urandom : fix_rdata;
      if (go || cnt == TO - 1) begin
        if (!suppress_cur) begin
          exp_rsp_q.push_back('{err: !go, dat: (go && cur.strb == 4'h0) ? rdata_i : 32'h0});
        end
        suppress_cur = 0;
        n_done++;
        last_vcyc = cnt + 1;
        in_req_m  = 0;
        cnt       = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Scoreboard for Wishbone responses
  always @(negedge clk) begin
    if (!arst_i) begin
      if (wb_ack_o && wb_err_o) fail_now("ack_and_err_together");
      if (wb_ack_o || wb_err_o) begin
        n_rsp++;
        last_err = wb_err_o;
        last_dat = wb_dat_o;
        if (exp_rsp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          chk("rsp_kind_err", wb_err_o, e.err);
          chk("rsp_dat", wb_dat_o, e.dat);
        end
      end
    end
  end

  // Driver tasks (called just after a rising edge)
  task automatic wb_push(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat);
    bit acc;
    int tries;
    tries    = 0;
    acc      = 0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_dat_i = dat;
    while (!acc) begin
      acc = !wb_stall_o;
      @(posedge clk); #1;
      if (!acc) begin
        tries++;
        if (tries > 60) begin
          fail_now("push_stalled");
          break;
        end
      end
    end
    if (acc) exp_iob_q.push_back('{adr: adr, strb: (we ? sel : 4'h0), dat: dat});
    wb_stb_i = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (n_rsp < target) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        fail_now("wait_rsp");
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_iob_q.size() != 0 || exp_rsp_q.size() != 0 || valid_o || level_o != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        fail_now("drain");
        break;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int base_rsp, base_done;
    bit gap;
    vecs[0] = '{32'h10, 1'b0, 4'hF, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'h0, 4};
    vecs[1] = '{32'h20, 1'b1, 4'h5, 32'h11223344, 0, 32'hCAFEF00D, 1'b0, 32'h0,        4'h5, 1};
    vecs[2] = '{32'h30, 1'b0, 4'hF, 32'h0,       20, 32'h12345678, 1'b1, 32'h0,        4'h0, 8};
    vecs[3] = '{32'h40, 1'b0, 4'h3, 32'h0,        7, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 4'h0, 8};
    vecs[4] = '{32'h50, 1'b1, 4'hF, 32'hFFFF0000, 8, 32'h0,        1'b1, 32'h0,        4'hF, 8};
    vecs[5] = '{32'h60, 1'b1, 4'hA, 32'h0BADC0DE, 2, 32'h13572468, 1'b0, 32'h0,        4'hA, 3};

    arst_i = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {valid_o, wb_ack_o, wb_err_o, wb_stall_o, level_o}, 0);
    chk("reset_payload", {address_o, wdata_o, wstrb_o, wb_dat_o}, 0);
    arst_i = 1'b0;
    @(posedge clk); #1;

    // Single-transaction vectors
    foreach (vecs[i]) begin
      rsp_mode  = 0;
      fix_lat   = vecs[i].lat;
      fix_rdata = vecs[i].rdata;
      base_rsp  = n_rsp;
      wb_push(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat);
      chk("vec_valid_n1", valid_o, 1'b0);
      @(posedge clk); #1;
      chk("vec_valid_n2", valid_o, 1'b1);
      wait_rsp(base_rsp + 1);
      chk("vec_err", last_err, vecs[i].exp_err);
      chk("vec_dat", last_dat, vecs[i].exp_dat);
      chk("vec_strb", last_strb, vecs[i].exp_strb);
      chk("vec_wdata", last_wdata, vecs[i].dat);
      chk("vec_adr", last_adr, vecs[i].adr);
      chk("vec_valid_cycles", last_vcyc, vecs[i].exp_vcyc);
      drain();
    end

    // Burst against a stalled IOb slave, then full-rate completion
    rsp_mode  = 2;
    base_rsp  = n_rsp;
    base_done = n_done;
    for (int i = 0; i < 5; i++) wb_push(32'h1000 + 32'(i * 4), 1'b1, 4'hF, 32'hB000 + 32'(i));
    chk("burst_level_full", level_o, 3'd4);
    chk("burst_stall", wb_stall_o, 1'b1);
    rsp_mode = 0;
    fix_lat  = 0;
    wb_push(32'h1014, 1'b1, 4'hF, 32'hB005);
    gap = 0;
    for (int n = 0; n < 60 && n_done < base_done + 6; n++) begin
      if (!valid_o) gap = 1;
      @(posedge clk); #1;
    end
    chk("burst_valid_continuous", gap, 1'b0);
    wait_rsp(base_rsp + 6);
    drain();
    chk("burst_ack_count", n_rsp - base_rsp, 6);

    // Abort with the first of three requests in flight
    rsp_mode  = 0;
    fix_lat   = 5;
    fix_rdata = 32'h5EED5EED;
    base_rsp  = n_rsp;
    base_done = n_done;
    wb_push(32'h100, 1'b0, 4'hF, 32'h0);
    wb_push(32'h104, 1'b0, 4'hF, 32'h0);
    wb_push(32'h108, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    suppress_cur = 1;
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    exp_iob_q.delete();
    chk("abort_level", level_o, 3'd0);
    chk("abort_inflight_valid", valid_o, 1'b1);
    wb_push(32'h10C, 1'b0, 4'hF, 32'h0);
    drain();
    chk("abort_rsp_count", n_rsp - base_rsp, 1);
    chk("abort_iob_done_count", n_done - base_done, 2);
    chk("abort_new_dat", last_dat, 32'h5EED5EED);

    // Asynchronous reset in the middle of a request with two queued behind it
    rsp_mode = 2;
    wb_push(32'h200, 1'b1, 4'h1, 32'h1);
    wb_push(32'h204, 1'b1, 4'h2, 32'h2);
    wb_push(32'h208, 1'b1, 4'h4, 32'h3);
    @(posedge clk); #1;
    arst_i = 1'b1;
    #1;
    chk("arst_outputs", {valid_o, wb_ack_o, wb_err_o, wb_stall_o, level_o}, 0);
    chk("arst_payload", {address_o, wdata_o, wstrb_o, wb_dat_o}, 0);
    exp_iob_q.delete();
    exp_rsp_q.delete();
    wb_cyc_i = 1'b0;
    base_rsp = n_rsp;
    repeat (2) @(posedge clk);
    #1;
    arst_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_no_rsp", n_rsp - base_rsp, 0);
    rsp_mode  = 0;
    fix_lat   = 2;
    fix_rdata = 32'h600DF00D;
    wb_push(32'h300, 1'b0, 4'h0, 32'h0);
    wait_rsp(base_rsp + 1);
    drain();
    chk("arst_after_dat", last_dat, 32'h600DF00D);
    chk("arst_after_count", n_rsp - base_rsp, 1);

    // Random traffic with random IOb latency, timeouts and ready noise while idle
    rsp_mode   = 1;
    idle_noise = 1;
    base_rsp   = n_rsp;
    for (int i = 0; i < 40; i++) begin
      wb_push($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    idle_noise = 0;
    chk("random_rsp_count", n_rsp - base_rsp, 40);
    chk("final_queues_empty", exp_iob_q.size() + exp_rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
